// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// mux select codes and the packed control word driven by mc_ctrl.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11,
    S_JALEX   = 4'd12,
    S_JREX    = 4'd13,
    S_RSV14   = 4'd14,
    S_RSV15   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       signext;
    logic       shiftl16;
    logic       link;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
      OP_ORI, OP_LUI, OP_J, OP_JAL: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and flags in, mux selects and enables out.
// master is the controller side, slave the datapath side.
interface mc_ctrl_if #(parameter int STATE_W = 4);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pcen;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [1:0]         aluop;
  logic               signext;
  logic               shiftl16;
  logic               link;
  logic               illegal;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, aluop, signext, shiftl16, link, illegal, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, aluop, signext, shiftl16, link, illegal, state_o
  );
endinterface

// File: rtl/mc_ctrl_next.sv
// Combinational next-state logic for the multicycle control FSM.
// Zero latency; rdy holds FETCH/MEMRD/MEMWR until the memory access completes.
module mc_ctrl_next
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       rdy,
  output state_t     next
);

  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                    next = S_MEMADR;
          OP_RTYPE:                        next = (funct == FN_JR) ? S_JREX : S_RTYPEEX;
          OP_BEQ, OP_BNE:                  next = S_BREX;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: next = S_IMMEX;
          OP_J:                            next = S_JEX;
          OP_JAL:                          next = S_JALEX;
          default:                         next = S_FETCH;
        endcase
      end
      S_MEMADR:  next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   next = rdy ? S_FETCH : S_MEMWR;
      S_RTYPEEX: next = S_RTYPEWB;
      S_IMMEX:   next = S_IMMWB;
      default:   next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: Moore outputs per state, refined by op in EX states.
// One state per cycle; MC_CTRL_MEMWAIT_EN makes mem_ready stall FETCH/MEMRD/MEMWR.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  mc_ctrl_if.master bus
);

  state_t state;
  state_t next;
  logic   rdy;
  ctrl_t  ctl;

`ifdef MC_CTRL_MEMWAIT_EN
  assign rdy = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign rdy = 1'b1;
`endif

  mc_ctrl_next u_next (
    .state (state),
    .op    (bus.op),
    .funct (bus.funct),
    .rdy   (rdy),
    .next  (next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next;
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.alusrcb = SRCB_FOUR;
        ctl.irwrite = rdy;
        ctl.pcen    = rdy;
      end
      S_DECODE: begin
        ctl.alusrcb = SRCB_IMMSH;
        ctl.signext = 1'b1;
        ctl.illegal = !op_legal(bus.op);
      end
      S_MEMADR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.signext = 1'b1;
      end
      S_MEMRD: ctl.iord = 1'b1;
      S_MEMWB: begin
        ctl.memtoreg = 1'b1;
        ctl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctl.iord     = 1'b1;
        ctl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_B;
        ctl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctl.regdst   = 1'b1;
        ctl.regwrite = 1'b1;
      end
      S_BREX: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALUOP_SUB;
        ctl.pcsrc   = PCSRC_ALUOUT;
        ctl.pcen    = (bus.op == OP_BNE) ? !bus.zero : bus.zero;
      end
      S_IMMEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        case (bus.op)
          OP_ORI:  ctl.aluop    = ALUOP_OR;
          OP_LUI:  ctl.shiftl16 = 1'b1;
          default: ctl.signext  = 1'b1;
        endcase
      end
      S_IMMWB: ctl.regwrite = 1'b1;
      S_JEX: begin
        ctl.pcsrc = PCSRC_JUMP;
        ctl.pcen  = 1'b1;
      end
      S_JALEX: begin
        // PC already holds PC+4 here; datapath routes it to $31 under link
        ctl.pcsrc    = PCSRC_JUMP;
        ctl.pcen     = 1'b1;
        ctl.link     = 1'b1;
        ctl.regwrite = 1'b1;
      end
      S_JREX: begin
        ctl.pcsrc = PCSRC_REGA;
        ctl.pcen  = 1'b1;
      end
      default: ctl = '0;
    endcase
    if (!reset_n) ctl = '0;
  end

  assign bus.pcen     = ctl.pcen;
  assign bus.iord     = ctl.iord;
  assign bus.memwrite = ctl.memwrite;
  assign bus.irwrite  = ctl.irwrite;
  assign bus.regdst   = ctl.regdst;
  assign bus.memtoreg = ctl.memtoreg;
  assign bus.regwrite = ctl.regwrite;
  assign bus.alusrca  = ctl.alusrca;
  assign bus.alusrcb  = ctl.alusrcb;
  assign bus.pcsrc    = ctl.pcsrc;
  assign bus.aluop    = ctl.aluop;
  assign bus.signext  = ctl.signext;
  assign bus.shiftl16 = ctl.shiftl16;
  assign bus.link     = ctl.link;
  assign bus.illegal  = ctl.illegal;
  assign bus.state_o  = reset_n ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl against an instruction-level model (state path per op class).
module tb_mc_ctrl;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ADDIU = 6'b001001, ORI = 6'b001101, LUI = 6'b001111;
  localparam logic [5:0] JMP = 6'b000010, JAL = 6'b000011, RTY = 6'b000000, JRF = 6'b001000;

  logic clk;
  logic reset_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   memwr_cnt;
  int   path[$];

  mc_ctrl_if #(.STATE_W(4)) bus ();

  mc_ctrl #(.STATE_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    logic [5:0] ops [11] = '{RTY, LW, SW, BEQ, BNE, ADDI, ADDIU, ORI, LUI, JMP, JAL};
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit eff_rdy(input logic mr);
`ifdef MC_CTRL_MEMWAIT_EN
    return mr;
`else
    return 1'b1;
`endif
  endfunction

  // Instruction-level view: the sequence of states each instruction class visits.
  function automatic void build_path(input logic [5:0] op, input logic [5:0] fn);
    path = '{0, 1};
    if (op == LW)                          path = '{0, 1, 2, 3, 4};
    else if (op == SW)                     path = '{0, 1, 2, 5};
    else if (op == RTY && fn == JRF)       path = '{0, 1, 13};
    else if (op == RTY)                    path = '{0, 1, 6, 7};
    else if (op == BEQ || op == BNE)       path = '{0, 1, 8};
    else if (op inside {ADDI, ADDIU, ORI, LUI}) path = '{0, 1, 9, 10};
    else if (op == JMP)                    path = '{0, 1, 11};
    else if (op == JAL)                    path = '{0, 1, 12};
  endfunction

  // Expected control word {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
  // alusrcb,pcsrc,aluop,signext,shiftl16,link,illegal} for a state of the instruction.
  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic z, input bit rdy);
    logic pcen = 0, iord = 0, mw = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, pcs = 0, aop = 0;
    logic sx = 0, sh = 0, lnk = 0, ill = 0;
    case (st)
      0:  begin sb = 2'b01; irw = rdy; pcen = rdy; end
      1:  begin sb = 2'b11; sx = 1; ill = !is_legal(op); end
      2:  begin sa = 1; sb = 2'b10; sx = 1; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; aop = 2'b11; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcen = (op == BEQ) ? z : !z; end
      9:  begin
            sa = 1; sb = 2'b10;
            if (op == ORI) aop = 2'b10;
            else if (op == LUI) sh = 1;
            else sx = 1;
          end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      12: begin pcs = 2'b10; pcen = 1; lnk = 1; rw = 1; end
      13: begin pcs = 2'b11; pcen = 1; end
      default: ;
    endcase
    return {pcen, iord, mw, irw, rdst, m2r, rw, sa, sb, pcs, aop, sx, sh, lnk, ill};
  endfunction

  function automatic logic [17:0] obs_ctrl();
    return {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop, bus.signext,
            bus.shiftl16, bus.link, bus.illegal};
  endfunction

  // Entry/exit at posedge+1. zmode: 0/1 fixed zero, 2 random. rmode: 0 random ready,
  // 1 always ready, 2 ready low for the first 3 MEMWR cycles. abort5 returns inside MEMWR.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           input int rmode, input bit abort5, input string tag);
    int idx = 0;
    int memwr_seen = 0;
    int st;
    logic mr;
    build_path(op, fn);
    memwr_cnt = 0;
    bus.op    = op;
    bus.funct = fn;
    for (int cyc = 0; cyc < 64 && idx < path.size(); cyc++) begin
      st       = path[idx];
      bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (rmode == 1)      mr = 1'b1;
      else if (rmode == 2) mr = !(st == 5 && memwr_seen < 3);
      else                 mr = ($urandom_range(0, 3) != 0);
      bus.mem_ready = mr;
      #1;
      chk({tag, "_state"}, 32'(bus.state_o), 32'(st));
      chk({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(st, op, bus.zero, eff_rdy(mr))));
      if (bus.memwrite) memwr_cnt++;
      if (st == 5) memwr_seen++;
      if (abort5 && st == 5) return;
      if (!(st inside {0, 3, 5}) || eff_rdy(mr)) idx++;
      @(posedge clk);
      #1;
    end
    if (idx < path.size()) chk({tag, "_timeout"}, 32'(idx), 32'(path.size()));
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [11] = '{RTY, LW, SW, BEQ, BNE, ADDI, ADDIU, ORI, LUI, JMP, JAL};
    logic [5:0] o;
    if ($urandom_range(0, 9) == 0) begin
      o = 6'($urandom);
      while (is_legal(o)) o = 6'($urandom);
      return o;
    end
    return ops[$urandom_range(0, 10)];
  endfunction

  initial begin
    logic [5:0] o;
    logic [5:0] f;
    reset_n       = 1'b0;
    bus.op        = '0;
    bus.funct     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_state", 32'(bus.state_o), 32'd0);
    chk("rst_ctrl", 32'(obs_ctrl()), 32'd0);
    @(posedge clk); #1;
    chk("rst_ctrl2", 32'(obs_ctrl()), 32'd0);
    reset_n = 1'b1;

    run_instr(LW, 6'd0, 2, 1, 0, "lw");
    run_instr(BNE, 6'd0, 1, 1, 0, "bne_z1");
    run_instr(BNE, 6'd0, 0, 1, 0, "bne_z0");
    run_instr(BEQ, 6'd0, 1, 1, 0, "beq_z1");
    run_instr(JAL, 6'd0, 2, 1, 0, "jal");
    run_instr(RTY, JRF, 2, 1, 0, "jr");
    run_instr(ORI, 6'd0, 2, 1, 0, "ori");
    run_instr(LUI, 6'd0, 2, 1, 0, "lui");
    run_instr(SW, 6'd0, 2, 2, 0, "sw_wait");
`ifdef MC_CTRL_MEMWAIT_EN
    chk("sw_memwrite_cycles", 32'(memwr_cnt), 32'd4);
`else
    chk("sw_memwrite_cycles", 32'(memwr_cnt), 32'd1);
`endif
    run_instr(6'b111111, 6'd0, 2, 1, 0, "illegal");

    for (int i = 0; i < 300; i++) begin
      o = rand_op();
      f = ($urandom_range(0, 7) == 0) ? JRF : 6'($urandom);
      run_instr(o, f, 2, 0, 0, "rand");
    end

    // Reset arriving while SW waits in MEMWR abandons the store.
    run_instr(SW, 6'd0, 2, 2, 1, "sw_abort");
    reset_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'(obs_ctrl()), 32'd0);
    chk("midrst_state", 32'(bus.state_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("midrst_hold_ctrl", 32'(obs_ctrl()), 32'd0);
      chk("midrst_hold_memwrite", 32'(bus.memwrite), 32'd0);
    end
    reset_n = 1'b1;
    run_instr(ADDI, 6'd0, 2, 1, 0, "post_rst");
    for (int i = 0; i < 20; i++) run_instr(rand_op(), 6'($urandom), 2, 0, 0, "tail");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
